// File: rtl/uart_rx_ovs.sv
`timescale 1ns/1ps
// uart_rx_ovs
// Oversampling UART receiver that runs entirely on the system clock. A
// fractional-free tick generator produces OVERSAMPLE ticks per bit. Each bit
// is resolved by a 2-of-3 majority vote taken around the bit centre, and
// false starts are rejected. Completed words are offered on a valid/ready
// handshake with parity, framing and overrun reporting.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   rx_i         asynchronous serial line, idle high
//   data_o       received word, LSB first on the line
//   data_vld_o   data_o and the error flags are valid, held until accepted
//   data_rdy_i   consumer accepts the word when data_vld_o && data_rdy_i
//   parity_err_o parity mismatch for the held word (0 when PARITY="NONE")
//   frame_err_o  a stop bit of the held word was sampled low
//   overrun_o    one-clk pulse when a completed frame had to be dropped
//   busy_o       frame reception in progress
module uart_rx_ovs #(
    parameter int    CLK_FREQ_Hz = 27000000,
    parameter int    BAUD_RATE   = 9600,
    parameter int    OVERSAMPLE  = 16,
    parameter int    DATA_WIDTH  = 8,
    parameter string PARITY      = "NONE",
    parameter int    STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_vld_o,
    input  logic                  data_rdy_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int DIV     = CLK_FREQ_Hz / (BAUD_RATE * OVERSAMPLE);
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_WIDTH + 1);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Refuse to elaborate with a configuration the receiver cannot honour.
    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx_ovs: CLK_FREQ_Hz/(BAUD_RATE*OVERSAMPLE) must be at least 1");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_ovs_check
            $error("uart_rx_ovs: OVERSAMPLE must be even and at least 8");
        end
        if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : g_dw_check
            $error("uart_rx_ovs: DATA_WIDTH must be 5..9");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
            $error("uart_rx_ovs: STOP_BITS must be 1 or 2");
        end
        if ((PARITY != "NONE") && (PARITY != "ODD") && (PARITY != "EVEN")) begin : g_par_check
            $error("uart_rx_ovs: PARITY must be NONE, ODD or EVEN");
        end
    endgenerate

    logic [2:0]            state;
    logic                  sync1, sync2, hist;
    logic                  fall_edge;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [SW-1:0]         samp_cnt;
    logic                  s0, s1;
    logic                  decide, wrap, maj;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  stop_idx;
    logic                  ferr_acc;
    logic                  last_stop;
    logic                  complete;
    logic                  frame_err_new;
    logic                  parity_err_new;
    logic                  slot;

    // Two-flop synchroniser plus one history flop. Everything resets to the
    // idle level so a reset never manufactures a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign fall_edge = hist & ~sync2;

    // Tick generator. Parked at zero while idle so the first tick of a frame
    // lands a fixed distance from start detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if ((state == ST_IDLE) || (tick_cnt == TICK_LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (state != ST_IDLE) && (tick_cnt == TICK_LAST);

    // Position within the current bit, plus the first two of the three
    // centre samples. The third sample is the live synchroniser output at
    // the decision tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else if (state == ST_IDLE) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
            if (samp_cnt == S_LO) begin
                s0 <= sync2;
            end
            if (samp_cnt == S_MID) begin
                s1 <= sync2;
            end
        end
    end

    assign decide = tick && (samp_cnt == S_HI);
    assign wrap   = tick && (samp_cnt == S_LAST);
    assign maj    = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

    assign last_stop      = (STOP_BITS == 1) || stop_idx;
    assign frame_err_new  = ferr_acc | ~maj;
    assign parity_err_new = PAR_EN && (par_bit != ((^shreg) ^ PAR_ODD));
    assign complete       = (state == ST_STOP) && decide && last_stop;

    // Frame sequencer. The frame ends at the majority decision of the last
    // stop bit rather than at the bit boundary, leaving half a bit of slack
    // for the next start edge. An errored frame parks in BREAK until the line
    // goes high so a held-low line produces one word only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state    <= ST_START;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide && maj) begin
                        state <= ST_IDLE;
                    end else if (wrap) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                    end else if (wrap && (bit_idx == BW'(DATA_WIDTH))) begin
                        state <= PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        par_bit <= maj;
                    end else if (wrap) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        if (last_stop) begin
                            state <= frame_err_new ? ST_BREAK : ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            ferr_acc <= frame_err_new;
                        end
                    end
                end
                ST_BREAK: begin
                    if (sync2) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign slot = data_vld_o & ~data_rdy_i;

    // Output holding register. A word still waiting for the consumer wins
    // over a newly completed one; the newcomer is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o       <= '0;
            data_vld_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (complete) begin
                if (slot) begin
                    overrun_o <= 1'b1;
                end else begin
                    data_o       <= shreg;
                    parity_err_o <= parity_err_new;
                    frame_err_o  <= frame_err_new;
                    data_vld_o   <= 1'b1;
                end
            end else if (data_vld_o && data_rdy_i) begin
                data_vld_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Oversampling UART receiver that runs entirely in the system clock domain, with no derived clocks. It adds majority-vote sampling, false-start rejection, and parity and framing checks. Output uses a valid/ready handshake with overrun detection. It sits between the board RX pin and a byte consumer (FIFO or command parser) and is the drop-in successor for the divided-clock receiver.

## Interface
- CLK_FREQ_Hz, 27000000, system clock frequency.
- BAUD_RATE, 9600, line rate.
- OVERSAMPLE, 16, ticks per bit; must be even and ≥ 8.
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- PARITY, "NONE", one of "NONE", "ODD" or "EVEN".
- STOP_BITS, 1, legal 1 or 2.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous and active-high.
- rx_i  input  1  asynchronous serial line; idle high.
- data_o  output  DATA_WIDTH  received word, LSB-first on the line.
- data_vld_o  output  1  data_o and the error flags are valid; held until accepted.
- data_rdy_i  input  1  consumer accepts the word when data_vld_o && data_rdy_i.
- parity_err_o  output  1  parity mismatch for the held word; always 0 when PARITY="NONE".
- frame_err_o  output  1  a stop bit was sampled 0 for the held word.
- overrun_o  output  1  one-clk pulse when a completed frame is dropped.
- busy_o  output  1  frame reception in progress (state ≠ IDLE).

## Operation
- **Synchroniser:** 2-flop synchroniser on rx_i, reset to 1, followed by one edge-history flop. A falling edge is history=1, sync=0.
- **Tick generator:** DIV = CLK_FREQ_Hz/(BAUD_RATE*OVERSAMPLE), integer division. Elaboration fails if DIV < 1. The counter is held at 0 in IDLE and emits a one-clk tick every DIV clks otherwise.
- **Sample counter:** counts ticks 0..OVERSAMPLE-1 within a bit. Three samples are taken at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at count OVERSAMPLE/2+1.
- **FSM:** IDLE → START → DATA → PARITY (skipped if "NONE") → STOP → IDLE, plus a BREAK state.
  - IDLE: a falling edge moves the FSM to START and clears the tick and sample counters.
  - START: if the majority is 1, this is a false start; return to IDLE with no output and no flags. Otherwise enter DATA when the sample counter wraps.
  - DATA: shift in DATA_WIDTH bits, LSB first, using a bit index counter of width $clog2(DATA_WIDTH+1).
  - PARITY: expected parity is EVEN = XOR of the data bits, ODD = its inverse. parity_err = received ≠ expected.
  - STOP: STOP_BITS stop bits; frame_err = OR over each stop-bit majority == 0. The frame completes at the majority decision of the last stop bit, not at the end of the bit. This allows back-to-back frames with up to half a bit of skew.
  - Completion: go to IDLE if frame_err = 0, or to BREAK if frame_err = 1. BREAK waits for a synchronised rx of 1, then goes to IDLE, so a held-low line yields exactly one errored word.
- **Output register:** on completion, with slot = data_vld_o && !data_rdy_i:
  - If slot = 0: load data_o and both error flags, and set data_vld_o.
  - If slot = 1: keep the old word and flags, discard the new frame, and pulse overrun_o.
  - Completion and acceptance in the same clk count as slot = 0; the new word replaces the accepted one and data_vld_o stays 1.
  - Acceptance without completion clears data_vld_o. data_o and the flags keep their last values.

## Timing
- **Reset values:** data_o 0, data_vld_o 0, parity_err_o 0, frame_err_o 0, overrun_o 0, busy_o 0. FSM goes to IDLE and the synchroniser to 1s.
- **Reset mid-frame:** aborts with no output. After release, the first falling edge starts a fresh frame.
- **Start detection:** busy_o rises 3 clks after the rx_i falling edge (2 sync + 1 edge).
- **Bit k sample decision:** k=0 is start, then data, parity, stop. The decision occurs (k*OVERSAMPLE + OVERSAMPLE/2+2) ticks after start detection, ±1 clk.
- **Completion:** data_vld_o and the flags update 1 clk after the last stop-bit decision. busy_o falls in that same clk (or when BREAK exits).
- **Overrun:** overrun_o is high for exactly 1 clk, aligned with the clk in which data_vld_o would otherwise have reloaded.
- **Glitch rejection:** any low pulse shorter than OVERSAMPLE/2-1 ticks is rejected as a false start.

## Test plan
Common bench parameters: CLK_FREQ_Hz=16000000, BAUD_RATE=1000000, OVERSAMPLE=16, so DIV=1 and a bit is 16 clk.
- **Basic word:** 8N1, send 0xA5 with data_rdy_i=1 → data_o=0xA5, data_vld_o high 1 clk, both flags 0, ~9.5 bits after start.
- **Parity:** EVEN, send 0x07 with parity bit 0 → parity_err_o=1, data_o=0x07. Resend with parity 1 → parity_err_o=0. Repeat with ODD using the opposite parity bits.
- **False start:** 4-clk low glitch → busy_o pulses, no data_vld_o. A real 0x3C frame sent 5 clks later is received correctly.
- **Framing/break:** frame 0x55 with stop bit 0, line then held low for 40 clks → one word with frame_err_o=1, busy_o stays high until rx returns to 1. Next frame 0x12 → frame_err_o=0.
- **Overrun:** 3 back-to-back frames 0x01, 0x02, 0x03 with data_rdy_i=0, then assert data_rdy_i → 2 overrun_o pulses, the held word is 0x01, no later words.
- **Reset mid-frame:** assert rst at bit 4 of 0xFF → all outputs 0 immediately. After release, a 0x81 frame is received correctly.
